// File: rtl/fb_pkg.sv
// Frame-buffer package: geometry, widths, clear colour and the write-scheduler
// state encoding. The display and paint modules use the same definitions.
package fb_pkg;

    localparam int MAX_X     = 640;           // visible width, pixels
    localparam int MAX_Y     = 480;           // visible height, pixels
    localparam int ADDR_W    = 19;            // frame-buffer address width
    localparam int COLOR_W   = 3;             // pixel colour width
    localparam int COORD_W   = 10;            // width of one x or y coordinate
    localparam int FB_PIXELS = MAX_X * MAX_Y; // 307200 pixels

    localparam logic [COLOR_W-1:0] CLEAR_COLOR = 3'b000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//  clk, reset_n : clock, asynchronous active-low reset
//  en           : arbitration allowed this cycle (no grant when low)
//  req          : request vector
//  grant        : one-hot grant, combinational on req/en/pointer
// The pointer holds the last granted index; search starts one past it.
// Reset loads N-1 so index 0 has first priority.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] idx;
    logic          found;
    int            pos;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        next_ptr = ptr;
        idx      = '0;
        pos      = 0;
        for (int off = 1; off <= N; off++) begin
            // Walk ptr+1, ptr+2, ... wrapping modulo N.
            pos = int'(ptr) + off;
            if (pos >= N) pos = pos - N;
            idx = PW'(pos);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= PW'(N - 1);
        end else if (found) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write-port scheduler. Arbitrates single-pixel writes from
// N_REQ requesters (round-robin) and runs a full-screen clear sweep.
//  clk, reset_n : clock, asynchronous active-low reset
//  req_valid/x/y/color : per-requester pixel write (x,y packed 10 bits each)
//  req_ready    : one-hot accept pulse, combinational
//  clear_req    : pulse, start full-screen clear (ignored while clearing)
//  fb_we/fb_addr/fb_din : registered write port, addr = y*MAX_X + x
//  busy         : high during every clear write cycle
//  clear_done   : one-cycle pulse after the last clear write
//  drop_flag    : sticky, an out-of-range request was discarded
//  fsm_state    : current FSM state
// Handshake: a requester holds valid/x/y/color stable until it sees its
// req_ready bit high in a cycle; that cycle consumes the request. At most one
// ready bit is high per cycle, and never during reset, CLEAR or a clear_req cycle.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int N_REQ  = 5,
    parameter int SCR_X  = MAX_X,
    parameter int SCR_Y  = MAX_Y
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*COORD_W-1:0] req_x,
    input  logic [N_REQ*COORD_W-1:0] req_y,
    input  logic [N_REQ*COLOR_W-1:0] req_color,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     clear_req,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [COLOR_W-1:0]       fb_din,
    output logic                     busy,
    output logic                     clear_done,
    output logic                     drop_flag,
    output fb_state_t                fsm_state
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SCR_X * SCR_Y - 1);
    localparam logic [COORD_W:0]   X_LIM     = (COORD_W + 1)'(SCR_X);
    localparam logic [COORD_W:0]   Y_LIM     = (COORD_W + 1)'(SCR_Y);

    fb_state_t           state;
    logic [ADDR_W-1:0]   count;
    logic                arb_en;
    logic [N_REQ-1:0]    grant;
    logic                any_grant;
    logic [COORD_W-1:0]  sel_x;
    logic [COORD_W-1:0]  sel_y;
    logic [COLOR_W-1:0]  sel_color;
    logic                in_range;
    logic [ADDR_W-1:0]   pix_addr;

    // Clear wins over simultaneous requests; nothing is granted under reset.
    assign arb_en = reset_n && (state == IDLE) && !clear_req;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (arb_en),
        .req     (req_valid),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;
    assign fsm_state = state;

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_x     = req_x[i*COORD_W +: COORD_W];
                sel_y     = req_y[i*COORD_W +: COORD_W];
                sel_color = req_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
    assign pix_addr = ADDR_W'(sel_y) * ADDR_W'(SCR_X) + ADDR_W'(sel_x);

    // count always equals the address being presented on fb_addr in CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_din     <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            drop_flag  <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        count   <= '0;
                        fb_we   <= 1'b1;
                        fb_addr <= '0;
                        fb_din  <= CLEAR_COLOR;
                        busy    <= 1'b1;
                    end else if (any_grant) begin
                        fb_we   <= in_range;
                        fb_addr <= pix_addr;
                        fb_din  <= sel_color;
                        if (!in_range) drop_flag <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (count == LAST_ADDR) begin
                        state      <= IDLE;
                        count      <= '0;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        count   <= count + 1'b1;
                        fb_we   <= 1'b1;
                        fb_addr <= count + 1'b1;
                        fb_din  <= CLEAR_COLOR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
module tb_fb_write_scheduler;
    import fb_pkg::*;

    localparam int N   = 5;
    localparam int SX  = 640;
    localparam int SY  = 3;            // short screen keeps the clear sweep brief
    localparam int PIX = SX * SY;      // 1920

    logic                 clk;
    logic                 reset_n;
    logic [N-1:0]         req_valid;
    logic [N*COORD_W-1:0] req_x;
    logic [N*COORD_W-1:0] req_y;
    logic [N*COLOR_W-1:0] req_color;
    logic [N-1:0]         req_ready;
    logic                 clear_req;
    logic                 fb_we;
    logic [ADDR_W-1:0]    fb_addr;
    logic [COLOR_W-1:0]   fb_din;
    logic                 busy;
    logic                 clear_done;
    logic                 drop_flag;
    fb_state_t            fsm_state;

    int checks = 0;
    int errors = 0;

    fb_write_scheduler #(.N_REQ(N), .SCR_X(SX), .SCR_Y(SY)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .req_ready  (req_ready),
        .clear_req  (clear_req),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_din     (fb_din),
        .busy       (busy),
        .clear_done (clear_done),
        .drop_flag  (drop_flag),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*COORD_W +: COORD_W]     = COORD_W'(x);
        req_y[i*COORD_W +: COORD_W]     = COORD_W'(y);
        req_color[i*COLOR_W +: COLOR_W] = COLOR_W'(c);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester i in the round-robin run: x=3i+1, y=i%3, color=i+1.
    function automatic logic [63:0] rr_addr(input int i);
        return 64'((i % 3) * SX + (3 * i + 1));
    endfunction

    initial begin
        reset_n   = 1'b0;
        clear_req = 1'b0;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        req_color = '0;
        for (int i = 0; i < N; i++) set_req(i, 3 * i + 1, i % 3, i + 1);

        // reset with all valids high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we",    64'(fb_we), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(clear_done), 64'd0);
        chk("rst_drop",  64'(drop_flag), 64'd0);
        chk("rst_addr",  64'(fb_addr), 64'd0);

        // release: round-robin over all five, held for 10 cycles
        next_cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rr_ready", 64'(req_ready), 64'(1 << (k % 5)));
            if (k == 0) begin
                chk("rr_first_we", 64'(fb_we), 64'd0);
            end else begin
                chk("rr_we",   64'(fb_we), 64'd1);
                chk("rr_addr", 64'(fb_addr), rr_addr((k - 1) % 5));
                chk("rr_din",  64'(fb_din), 64'(((k - 1) % 5) + 1));
            end
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("rr_last_we",   64'(fb_we), 64'd1);
        chk("rr_last_addr", 64'(fb_addr), rr_addr(4));
        chk("rr_idle_rdy",  64'(req_ready), 64'd0);
        @(negedge clk);
        chk("idle_we", 64'(fb_we), 64'd0);

        // single write: requester 2 at (10,2) colour 101
        next_cycle();
        set_req(2, 10, 2, 5);
        req_valid = 5'b00100;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'b00100);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("single_we",   64'(fb_we), 64'd1);
        chk("single_addr", 64'(fb_addr), 64'd1290);
        chk("single_din",  64'(fb_din), 64'b101);

        // out of range x=640
        next_cycle();
        set_req(0, 640, 0, 7);
        req_valid = 5'b00001;
        @(negedge clk);
        chk("oor_x_ready", 64'(req_ready), 64'b00001);
        chk("oor_x_pre",   64'(drop_flag), 64'd0);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("oor_x_we",   64'(fb_we), 64'd0);
        chk("oor_x_drop", 64'(drop_flag), 64'd1);

        // out of range y=SY
        next_cycle();
        set_req(3, 0, SY, 2);
        req_valid = 5'b01000;
        @(negedge clk);
        chk("oor_y_ready", 64'(req_ready), 64'b01000);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("oor_y_we", 64'(fb_we), 64'd0);

        // bottom-right corner is legal; drop_flag stays set
        next_cycle();
        set_req(4, 639, 2, 6);
        req_valid = 5'b10000;
        @(negedge clk);
        chk("corner_ready", 64'(req_ready), 64'b10000);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("corner_we",   64'(fb_we), 64'd1);
        chk("corner_addr", 64'(fb_addr), 64'd1919);
        chk("drop_sticky", 64'(drop_flag), 64'd1);

        // clear with requester 1 valid in the same cycle
        next_cycle();
        set_req(1, 5, 1, 3);
        req_valid = 5'b00010;
        clear_req = 1'b1;
        @(negedge clk);
        chk("clr_no_ready", 64'(req_ready), 64'd0);
        chk("clr_busy_pre", 64'(busy), 64'd0);
        for (int i = 0; i < PIX; i++) begin
            next_cycle();
            clear_req = (i == 500);   // must be ignored mid-sweep
            @(negedge clk);
            chk("clr_sweep",
                64'({busy, fb_we, fb_addr, fb_din, req_ready, clear_done, fsm_state}),
                64'({1'b1, 1'b1, ADDR_W'(i), 3'b000, 5'b00000, 1'b0, CLEAR}));
        end
        next_cycle();
        clear_req = 1'b0;
        @(negedge clk);
        chk("clr_done",    64'(clear_done), 64'd1);
        chk("clr_busy_lo", 64'(busy), 64'd0);
        chk("clr_we_lo",   64'(fb_we), 64'd0);
        chk("clr_then_r1", 64'(req_ready), 64'b00010);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("clr_done_1cy", 64'(clear_done), 64'd0);
        chk("r1_we",        64'(fb_we), 64'd1);
        chk("r1_addr",      64'(fb_addr), 64'd645);
        chk("r1_din",       64'(fb_din), 64'd3);
        chk("no_requeue",   64'(busy), 64'd0);

        // reset in the middle of a clear
        next_cycle();
        clear_req = 1'b1;
        for (int i = 0; i <= 1000; i++) begin
            next_cycle();
            clear_req = 1'b0;
        end
        @(negedge clk);
        chk("mid_addr", 64'(fb_addr), 64'd1000);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we",    64'(fb_we), 64'd0);
        chk("mid_rst_busy",  64'(busy), 64'd0);
        chk("mid_rst_state", 64'(fsm_state), 64'(IDLE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_nodone", 64'(clear_done), 64'd0);
        end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_state", 64'(fsm_state), 64'(IDLE));
        chk("post_done",  64'(clear_done), 64'd0);
        chk("post_drop",  64'(drop_flag), 64'd0);
        next_cycle();
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        @(negedge clk);
        chk("restart_addr", 64'(fb_addr), 64'd0);
        chk("restart_we",   64'(fb_we), 64'd1);
        reset_n = 1'b0;

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
